// File: rtl/mips_seq_pkg.sv
// Shared types and defaults for the MIPS external instruction sequencer.
// Holds the controller state encoding and the CPU-facing constants.
package mips_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FETCH = 2'd2,
    S_EXEC  = 2'd3
  } seq_state_e;

  localparam logic [3:0]  SEQ_FETCH_STATE = 4'd0;
  localparam logic [31:0] SEQ_NOP_INST    = 32'h0000_0000;

endpackage

// File: rtl/mips_inst_fifo.sv
// Synchronous instruction FIFO with flush, occupancy level and registered head.
// Pushes into a full buffer and pops from an empty one are ignored.
module mips_inst_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [31:0]              din_i,
  output logic [31:0]              head_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && (lvl_q != LW'(DEPTH));
  assign do_pop  = pop_i && (lvl_q != '0);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   lvl_d = lvl_q + LW'(1);
        2'b01:   lvl_d = lvl_q - LW'(1);
        default: lvl_d = lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && do_push) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign level_o = lvl_q;

endmodule

// File: rtl/mips_inst_sequencer.sv
// Feeds host instructions into a multicycle MIPS CPU, one per fetch state.
// Issues NOP_INST whenever the buffer is empty at fetch time.
module mips_inst_sequencer
  import mips_seq_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter logic [3:0]  FETCH_STATE = SEQ_FETCH_STATE,
  parameter logic [31:0] NOP_INST    = SEQ_NOP_INST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   seq_en,
  input  logic                   flush,
  input  logic                   host_valid,
  input  logic [31:0]            host_inst,
  output logic                   host_ready,
  input  logic [3:0]             cpu_state,
  output logic                   ext_inst_en,
  output logic [31:0]            ext_inst,
  output logic [15:0]            issued_cnt,
  output logic [15:0]            nop_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;

  seq_state_e    state_q, state_d;
  logic [15:0]   issued_q, issued_d;
  logic [15:0]   nop_q, nop_d;
  logic [31:0]   head;
  logic [LW-1:0] lvl;
  logic          has_head;
  logic          push;
  logic          pop;

  assign has_head   = (lvl != '0);
  assign host_ready = (lvl < LW'(DEPTH)) && !rst && !flush;
  assign push       = host_valid && host_ready;
  assign pop        = (state_q == S_FETCH) && seq_en && has_head && !flush;

  mips_inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (host_inst),
    .head_o  (head),
    .level_o (lvl)
  );

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    nop_d       = nop_q;
    ext_inst_en = 1'b0;
    ext_inst    = 32'h0;
    unique case (state_q)
      S_IDLE: begin
        if (seq_en) state_d = S_WAIT;
      end
      S_WAIT: begin
        ext_inst_en = 1'b1;
        ext_inst    = has_head ? head : NOP_INST;
        if (cpu_state == FETCH_STATE) state_d = S_FETCH;
      end
      S_FETCH: begin
        ext_inst_en = 1'b1;
        ext_inst    = has_head ? head : NOP_INST;
        state_d     = S_EXEC;
        if (pop) issued_d = issued_q + 16'd1;
        else     nop_d    = nop_q + 16'd1;
      end
      S_EXEC: begin
        ext_inst_en = 1'b1;
        ext_inst    = has_head ? head : NOP_INST;
        if (cpu_state != FETCH_STATE) state_d = S_WAIT;
      end
    endcase
    // Disabling freezes the stream without consuming or counting.
    if (!seq_en) begin
      state_d  = S_IDLE;
      issued_d = issued_q;
      nop_d    = nop_q;
    end
    if (rst) begin
      ext_inst_en = 1'b0;
      ext_inst    = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      issued_q <= 16'd0;
      nop_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      nop_q    <= nop_d;
    end
  end

  assign issued_cnt = issued_q;
  assign nop_cnt    = nop_q;
  assign level      = lvl;

endmodule

// File: tb/tb_mips_inst_sequencer.sv
// Directed self-checking bench for mips_inst_sequencer (DEPTH=4).
module tb_mips_inst_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        seq_en;
  logic        flush;
  logic        host_valid;
  logic [31:0] host_inst;
  logic        host_ready;
  logic [3:0]  cpu_state;
  logic        ext_inst_en;
  logic [31:0] ext_inst;
  logic [15:0] issued_cnt;
  logic [15:0] nop_cnt;
  logic [2:0]  level;

  int n_run  = 0;
  int n_fail = 0;
  int pushed;

  always #5 clk = ~clk;

  mips_inst_sequencer #(
    .DEPTH       (4),
    .FETCH_STATE (4'd0),
    .NOP_INST    (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seq_en      (seq_en),
    .flush       (flush),
    .host_valid  (host_valid),
    .host_inst   (host_inst),
    .host_ready  (host_ready),
    .cpu_state   (cpu_state),
    .ext_inst_en (ext_inst_en),
    .ext_inst    (ext_inst),
    .issued_cnt  (issued_cnt),
    .nop_cnt     (nop_cnt),
    .level       (level)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    host_valid = 1'b1;
    host_inst  = w;
    tick();
    host_valid = 1'b0;
  endtask

  // From S_WAIT: one fetch state, then three non-fetch states.
  task automatic fetch_cycle(input string tag, input logic [31:0] exp);
    #1;
    chk(tag, ext_inst, exp);
    cpu_state = 4'd0; tick();
    cpu_state = 4'd1; tick();
    tick();
    cpu_state = 4'd2; tick();
    cpu_state = 4'd3; tick();
    cpu_state = 4'd1;
  endtask

  function automatic logic [31:0] sw(input int i);
    return 32'h2000_0000 | (i * 32'h0101);
  endfunction

  initial begin
    rst = 1'b1; seq_en = 1'b0; flush = 1'b0;
    host_valid = 1'b0; host_inst = 32'h0; cpu_state = 4'd1;
    tick();
    #1;
    chk("rst_ready", 32'(host_ready), 32'd0);
    chk("rst_en", 32'(ext_inst_en), 32'd0);
    chk("rst_inst", ext_inst, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(host_ready), 32'd1);
    chk("rel_level", 32'(level), 32'd0);
    chk("rel_issued", 32'(issued_cnt), 32'd0);
    chk("rel_nop", 32'(nop_cnt), 32'd0);

    // three words issued in order
    seq_en = 1'b1;
    push(32'h2008_0005);
    push(32'h2009_0003);
    push(32'h0109_5020);
    #1;
    chk("p3_level", 32'(level), 32'd3);
    chk("p3_en", 32'(ext_inst_en), 32'd1);
    fetch_cycle("p3_i0", 32'h2008_0005);
    fetch_cycle("p3_i1", 32'h2009_0003);
    fetch_cycle("p3_i2", 32'h0109_5020);
    #1;
    chk("p3_issued", 32'(issued_cnt), 32'd3);
    chk("p3_level0", 32'(level), 32'd0);
    chk("p3_nopinst", ext_inst, 32'h0);

    // long fetch on empty buffer: a single NOP
    cpu_state = 4'd0;
    tick(); tick(); tick();
    #1;
    chk("lf_nop", 32'(nop_cnt), 32'd1);
    chk("lf_inst", ext_inst, 32'h0);
    chk("lf_en", 32'(ext_inst_en), 32'd1);
    cpu_state = 4'd1;
    tick();
    #1;
    chk("lf_nop2", 32'(nop_cnt), 32'd1);

    // five pushes into four entries
    for (int i = 0; i < 5; i++) begin
      host_valid = 1'b1;
      host_inst  = 32'hA000_0000 + i;
      #1;
      chk("full_ready", 32'(host_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    chk("full_level", 32'(level), 32'd4);
    chk("full_ready4", 32'(host_ready), 32'd0);
    cpu_state = 4'd0; tick();
    #1;
    chk("full_fetch_ready", 32'(host_ready), 32'd0);
    cpu_state = 4'd1; tick();
    #1;
    chk("full_pop_level", 32'(level), 32'd3);
    chk("full_pop_ready", 32'(host_ready), 32'd1);
    tick();
    host_valid = 1'b0;
    #1;
    chk("full_refill", 32'(level), 32'd4);
    for (int i = 1; i < 5; i++)
      fetch_cycle("full_order", 32'hA000_0000 + i);
    #1;
    chk("full_issued", 32'(issued_cnt), 32'd8);

    // flush overrides a simultaneous push
    push(32'hB000_0000);
    push(32'hB000_0001);
    #1;
    chk("fl_level2", 32'(level), 32'd2);
    flush = 1'b1; host_valid = 1'b1; host_inst = 32'hB000_0002;
    #1;
    chk("fl_ready", 32'(host_ready), 32'd0);
    tick();
    flush = 1'b0; host_valid = 1'b0;
    #1;
    chk("fl_level0", 32'(level), 32'd0);
    chk("fl_inst", ext_inst, 32'h0);
    chk("fl_issued", 32'(issued_cnt), 32'd8);
    chk("fl_nop", 32'(nop_cnt), 32'd1);

    // disable in S_EXEC, resume with the same head
    push(32'hC000_0000);
    push(32'hC000_0001);
    push(32'hC000_0002);
    cpu_state = 4'd0; tick();
    cpu_state = 4'd1; tick();
    #1;
    chk("dis_level", 32'(level), 32'd2);
    chk("dis_head", ext_inst, 32'hC000_0001);
    seq_en = 1'b0;
    tick();
    #1;
    chk("dis_en", 32'(ext_inst_en), 32'd0);
    chk("dis_inst", ext_inst, 32'h0);
    chk("dis_level2", 32'(level), 32'd2);
    cpu_state = 4'd0; tick(); tick();
    #1;
    chk("dis_hold", 32'(level), 32'd2);
    cpu_state = 4'd1; seq_en = 1'b1;
    tick();
    #1;
    chk("res_en", 32'(ext_inst_en), 32'd1);
    fetch_cycle("res_i1", 32'hC000_0001);
    fetch_cycle("res_i2", 32'hC000_0002);
    #1;
    chk("res_issued", 32'(issued_cnt), 32'd11);

    // disable during S_FETCH: nothing consumed or counted
    push(32'hD000_0000);
    cpu_state = 4'd0; tick();
    seq_en = 1'b0; tick();
    #1;
    chk("dfe_level", 32'(level), 32'd1);
    chk("dfe_issued", 32'(issued_cnt), 32'd11);
    chk("dfe_nop", 32'(nop_cnt), 32'd1);
    seq_en = 1'b1; cpu_state = 4'd1; tick();
    fetch_cycle("dfe_i0", 32'hD000_0000);

    // push into empty buffer during S_FETCH: no bypass
    cpu_state = 4'd0; tick();
    host_valid = 1'b1; host_inst = 32'hE000_0000;
    #1;
    chk("byp_inst", ext_inst, 32'h0);
    tick();
    host_valid = 1'b0; cpu_state = 4'd1; tick();
    #1;
    chk("byp_nop", 32'(nop_cnt), 32'd2);
    chk("byp_level", 32'(level), 32'd1);
    fetch_cycle("byp_i0", 32'hE000_0000);

    // flushed S_FETCH counts a NOP
    push(32'hF000_0000);
    cpu_state = 4'd0; tick();
    flush = 1'b1; tick();
    flush = 1'b0; cpu_state = 4'd1; tick();
    #1;
    chk("ffe_nop", 32'(nop_cnt), 32'd3);
    chk("ffe_issued", 32'(issued_cnt), 32'd13);
    chk("ffe_level", 32'(level), 32'd0);

    // streaming 20 words through a full buffer
    for (int i = 0; i < 4; i++) push(sw(i));
    pushed = 4;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("stream", ext_inst, sw(k));
      cpu_state = 4'd0; tick();
      cpu_state = 4'd1; tick();
      if (pushed < 20) begin
        host_valid = 1'b1;
        host_inst  = sw(pushed);
        pushed++;
      end
      tick();
      host_valid = 1'b0;
    end
    #1;
    chk("stream_issued", 32'(issued_cnt), 32'd33);
    chk("stream_level", 32'(level), 32'd0);
    chk("stream_nop", 32'(nop_cnt), 32'd3);

    // reset mid-operation
    push(32'h1111_0000);
    push(32'h1111_0001);
    rst = 1'b1; host_valid = 1'b1; host_inst = 32'h1111_0002;
    #1;
    chk("mrst_ready", 32'(host_ready), 32'd0);
    chk("mrst_en", 32'(ext_inst_en), 32'd0);
    chk("mrst_inst", ext_inst, 32'h0);
    tick();
    rst = 1'b0; host_valid = 1'b0;
    #1;
    chk("mrst_level", 32'(level), 32'd0);
    chk("mrst_issued", 32'(issued_cnt), 32'd0);
    chk("mrst_nop", 32'(nop_cnt), 32'd0);
    chk("mrst_idle", 32'(ext_inst_en), 32'd0);
    tick();
    #1;
    chk("mrst_wait_en", 32'(ext_inst_en), 32'd1);
    chk("mrst_wait_inst", ext_inst, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_inst_sequencer.md
MIPS_INST_SEQUENCER -- requirements
Module: mips_inst_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, meaning instruction buffer entries (power of two, 2..16).
REQ-002 Parameter FETCH_STATE, default 4'd0, meaning the current_state encoding of the CPU fetch state.
REQ-003 Parameter NOP_INST, default 32'h0000_0000, meaning the instruction issued when the buffer is empty.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 seq_en  in  1  1 = sequencer drives the CPU instruction stream; 0 = CPU runs internal program.
REQ-007 flush  in  1  discard all buffered instructions.
REQ-008 host_valid  in  1  host offers host_inst.
REQ-009 host_inst  in  32  instruction word from host.
REQ-010 host_ready  out  1  buffer can accept a word this cycle.
REQ-011 cpu_state  in  4  CPU multicycle FSM state (current_state).
REQ-012 ext_inst_en  out  1  to CPU extInst_en.
REQ-013 ext_inst  out  32  to CPU extInst.
REQ-014 issued_cnt  out  16  count of buffered instructions issued.
REQ-015 nop_cnt  out  16  count of NOP_INST fills issued.
REQ-016 level  out  $clog2(DEPTH)+1  buffered entries.

Function
REQ-017 FSM states SHALL be S_IDLE, S_WAIT, S_FETCH, S_EXEC.
REQ-018 S_IDLE: ext_inst_en=0, ext_inst=0; seq_en=1 -> S_WAIT.
REQ-019 S_WAIT: ext_inst_en=1; cpu_state==FETCH_STATE -> S_FETCH.
REQ-020 S_FETCH (exactly one cycle): pop head if level>0 and increment issued_cnt, else increment nop_cnt; -> S_EXEC.
REQ-021 S_EXEC: ext_inst_en=1; cpu_state!=FETCH_STATE -> S_WAIT; a fetch state lasting multiple cycles SHALL cause exactly one pop.
REQ-022 In S_WAIT/S_FETCH/S_EXEC, ext_inst SHALL equal buffer head when level>0, else NOP_INST, combinationally from registered head.
REQ-023 seq_en=0 in any state SHALL force S_IDLE next cycle, with no pop in that cycle; buffer contents retained.
REQ-024 host_ready SHALL be 1 iff level<DEPTH and rst=0 and flush=0 (registered level, no pass-through when full).
REQ-025 Push SHALL occur iff host_valid and host_ready; push and pop in the same cycle SHALL leave level unchanged and preserve order.
REQ-026 Pop from empty buffer SHALL not alter level or pointers (NOP issued instead).
REQ-027 Push into empty buffer in the same cycle as an S_FETCH SHALL NOT bypass: NOP issued, pushed word stays buffered.
REQ-028 flush SHALL zero level and pointers next cycle, overriding push and pop that cycle; counters and FSM state unaffected, except a flushed S_FETCH counts a NOP.
REQ-029 Pointers SHALL wrap modulo DEPTH; counters SHALL wrap 16'hFFFF -> 0.

Reset
REQ-030 rst SHALL set FSM to S_IDLE, level/pointers/issued_cnt/nop_cnt to 0, ext_inst_en=0, ext_inst=0, host_ready=0 in that cycle.
REQ-031 rst mid-operation SHALL discard buffered words and override seq_en, flush and host_valid.

Structure
REQ-032 Package mips_seq_pkg SHALL hold the state enum, default FETCH_STATE and NOP_INST constants.
REQ-033 Buffer SHALL be sub-module mips_inst_fifo (synchronous FIFO with push, pop, flush, level, head).
REQ-034 Controller and counters SHALL reside in mips_inst_sequencer; no latches, single clock domain.

Verification
REQ-035 Reset, seq_en=1, push 3 words (0x20080005, 0x20090003, 0x01095020), cpu_state cycles 0,1,2,3 -> ext_inst issues them in order, issued_cnt=3, level=0.
REQ-036 Push 5 words with DEPTH=4, no fetch -> host_ready drops after 4th, 5th held until a pop, level=4.
REQ-037 Empty buffer, cpu_state=0 for 3 consecutive cycles -> nop_cnt=1, ext_inst=0x00000000.
REQ-038 level=2, flush asserted with simultaneous host_valid -> level=0 next cycle, pushed word dropped.
REQ-039 seq_en dropped during S_EXEC with level=2 -> ext_inst_en=0 next cycle, level stays 2; re-enable resumes with same head.
REQ-040 Full-DEPTH push/pop streaming for 20 instructions -> pointer wrap, order preserved, issued_cnt=20.
